// File: rtl/imm_pkg.sv
// Shared immediate-generator encodings, opcodes and format resolution.
// Imported by the extractor and the pipelined wrapper.
package imm_pkg;

  typedef enum logic [2:0] {
    FMT_R    = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_J    = 3'd4,
    FMT_U    = 3'd5,
    FMT_RSV  = 3'd6,
    FMT_AUTO = 3'd7
  } fmt_e;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_FULL,
    ST_SKID
  } state_e;

  typedef struct packed {
    fmt_e fmt;
    logic illegal;
  } dec_t;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  function automatic dec_t fmt_from_op(
    input logic [6:0] op
  );
    dec_t d;
    d.fmt     = FMT_R;
    d.illegal = 1'b0;
    case (op)
      OP_IMM, OP_LOAD,
      OP_JALR, OP_SYSTEM: d.fmt = FMT_I;
      OP_STORE:           d.fmt = FMT_S;
      OP_BRANCH:          d.fmt = FMT_B;
      OP_JAL:             d.fmt = FMT_J;
      OP_LUI, OP_AUIPC:   d.fmt = FMT_U;
      OP_REG:             d.fmt = FMT_R;
      default:            d.illegal = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/imm_gen_pipe_extract.sv
// Combinational immediate extraction: instruction + format -> XLEN imm.
// Shared with the compressed-instruction expander.
module imm_extract
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     inst_i,
  input  fmt_e            fmt_i,
  output logic [XLEN-1:0] imm_o
);

  logic [31:0] imm32;
  logic        s;

  assign s = inst_i[31];

  always_comb begin
    imm32 = '0;
    case (fmt_i)
      FMT_I: imm32 = {{20{s}}, inst_i[31:20]};
      FMT_S: imm32 = {{20{s}}, inst_i[31:25],
                      inst_i[11:7]};
      FMT_B: imm32 = {{19{s}}, s, inst_i[7],
                      inst_i[30:25],
                      inst_i[11:8], 1'b0};
      FMT_J: imm32 = {{11{s}}, s,
                      inst_i[19:12],
                      inst_i[20],
                      inst_i[30:21], 1'b0};
      FMT_U: imm32 = {inst_i[31:12], 12'h000};
      default: imm32 = '0;
    endcase
  end

  assign imm_o = XLEN'($signed(imm32));

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator with format auto-decode and a
// two-entry main/skid output store on a valid/ready handshake.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      inst,
  input  logic [2:0]       immsel,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  imm,
  output logic [2:0]       fmt,
  output logic             illegal,
  output logic [TAG_W-1:0] out_tag
);

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    fmt_e             fmt;
    logic             illegal;
    logic [TAG_W-1:0] tag;
  } ent_t;

  dec_t            dec;
  logic [XLEN-1:0] new_imm;
  ent_t            new_ent;

  state_e state_q;
  ent_t   main_q;
  ent_t   skid_q;
  logic   in_ready_q;
  logic   out_valid_q;

  logic xfer_in;
  logic xfer_out;

  always_comb begin
    dec.fmt     = FMT_R;
    dec.illegal = 1'b0;
    unique case (1'b1)
      immsel == FMT_AUTO: dec = fmt_from_op(inst[6:0]);
      immsel == FMT_RSV:  dec.illegal = 1'b1;
      default:            dec.fmt = fmt_e'(immsel);
    endcase
  end

  imm_extract #(
    .XLEN(XLEN)
  ) u_ext (
    .inst_i(inst),
    .fmt_i (dec.fmt),
    .imm_o (new_imm)
  );

  assign new_ent = '{
    imm:     new_imm,
    fmt:     dec.fmt,
    illegal: dec.illegal,
    tag:     in_tag
  };

  assign xfer_in  = in_valid & in_ready_q;
  assign xfer_out = out_valid_q & out_ready;

  // in_ready is a flop, so out_ready never reaches it combinationally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (xfer_in) begin
            main_q      <= new_ent;
            out_valid_q <= 1'b1;
            state_q     <= ST_FULL;
          end
        end
        ST_FULL: begin
          if (xfer_in && xfer_out) begin
            main_q <= new_ent;
          end else if (xfer_in) begin
            skid_q     <= new_ent;
            in_ready_q <= 1'b0;
            state_q    <= ST_SKID;
          end else if (xfer_out) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_EMPTY;
          end
        end
        ST_SKID: begin
          if (xfer_out) begin
            main_q     <= skid_q;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
            state_q    <= ST_FULL;
          end
        end
        default: state_q <= ST_EMPTY;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign imm       = main_q.imm;
  assign fmt       = main_q.fmt;
  assign illegal   = main_q.illegal;
  assign out_tag   = main_q.tag;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances
// share stimulus; expectations are hand-computed constants.
module tb_imm_gen_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] inst;
  logic [2:0]  immsel;
  logic [3:0]  in_tag;
  logic        out_ready;

  logic        rdy_a, vld_a, ill_a;
  logic [31:0] imm_a;
  logic [2:0]  fmt_a;
  logic [3:0]  tag_a;

  logic        rdy_b, vld_b, ill_b;
  logic [63:0] imm_b;
  logic [2:0]  fmt_b;
  logic [3:0]  tag_b;

  int n_tot;
  int n_pass;

  imm_gen_pipe #(.XLEN(32), .TAG_W(4)) u_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (rdy_a),
    .inst     (inst),
    .immsel   (immsel),
    .in_tag   (in_tag),
    .out_valid(vld_a),
    .out_ready(out_ready),
    .imm      (imm_a),
    .fmt      (fmt_a),
    .illegal  (ill_a),
    .out_tag  (tag_a)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(4)) u_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (rdy_b),
    .inst     (inst),
    .immsel   (immsel),
    .in_tag   (in_tag),
    .out_valid(vld_b),
    .out_ready(out_ready),
    .imm      (imm_b),
    .fmt      (fmt_b),
    .illegal  (ill_b),
    .out_tag  (tag_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h",
                  tag, got, exp);
  endtask

  task automatic send1(
    input logic [2:0]  sel,
    input logic [31:0] ins,
    input logic [3:0]  tg
  );
    @(negedge clk);
    immsel   = sel;
    inst     = ins;
    in_tag   = tg;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] got_q[$];
    int         acc;
    int         nemit;
    logic [3:0] last_tag;

    n_tot     = 0;
    n_pass    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    inst      = '0;
    immsel    = '0;
    in_tag    = '0;
    out_ready = 1'b1;

    repeat (2) @(negedge clk);
    chk("rst_vld", {63'd0, vld_a}, 64'd0);
    chk("rst_rdy", {63'd0, rdy_a}, 64'd1);
    chk("rst_imm", {32'd0, imm_a}, 64'd0);
    chk("rst_fmt", {61'd0, fmt_a}, 64'd0);
    chk("rst_ill", {63'd0, ill_a}, 64'd0);
    chk("rst_tag", {60'd0, tag_a}, 64'd0);
    chk("rst_imm64", imm_b, 64'd0);
    rst_n = 1'b1;

    // I format, explicit select
    send1(3'd1, 32'hFFF00093, 4'd3);
    chk("i_vld", {63'd0, vld_a}, 64'd1);
    chk("i_imm", {32'd0, imm_a}, 64'h0000_0000_FFFF_FFFF);
    chk("i_fmt", {61'd0, fmt_a}, 64'd1);
    chk("i_ill", {63'd0, ill_a}, 64'd0);
    chk("i_tag", {60'd0, tag_a}, 64'd3);
    chk("i_imm64", imm_b, 64'hFFFF_FFFF_FFFF_FFFF);

    // AUTO S then B back-to-back
    @(negedge clk);
    immsel   = 3'd7;
    inst     = 32'h00112623;
    in_tag   = 4'd5;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    inst   = 32'hFE000CE3;
    in_tag = 4'd6;
    @(negedge clk);
    chk("s_imm", {32'd0, imm_a}, 64'h0000_0000_0000_000C);
    chk("s_fmt", {61'd0, fmt_a}, 64'd2);
    chk("s_tag", {60'd0, tag_a}, 64'd5);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("b_vld", {63'd0, vld_a}, 64'd1);
    chk("b_imm", {32'd0, imm_a}, 64'h0000_0000_FFFF_FFF8);
    chk("b_fmt", {61'd0, fmt_a}, 64'd3);
    chk("b_tag", {60'd0, tag_a}, 64'd6);

    // AUTO J and U on XLEN=64
    send1(3'd7, 32'hFFDFF06F, 4'd1);
    chk("j_imm64", imm_b, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("j_fmt", {61'd0, fmt_b}, 64'd4);
    send1(3'd7, 32'h800000B7, 4'd2);
    chk("u_imm64", imm_b, 64'hFFFF_FFFF_8000_0000);
    chk("u_fmt", {61'd0, fmt_b}, 64'd5);
    chk("u_imm32", {32'd0, imm_a}, 64'h0000_0000_8000_0000);

    // illegal cases
    send1(3'd7, 32'h0000007F, 4'd4);
    chk("bad_op_ill", {63'd0, ill_a}, 64'd1);
    chk("bad_op_imm", imm_b, 64'd0);
    chk("bad_op_fmt", {61'd0, fmt_a}, 64'd0);
    send1(3'd6, 32'hFFF00093, 4'd4);
    chk("rsv_ill", {63'd0, ill_a}, 64'd1);
    chk("rsv_imm", imm_b, 64'd0);
    chk("rsv_fmt", {61'd0, fmt_a}, 64'd0);

    // backpressure: tags 1..4
    @(negedge clk);
    immsel    = 3'd1;
    inst      = 32'h00500093;
    in_tag    = 4'd1;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    acc       = 0;
    for (int cyc = 0; cyc < 14; cyc++) begin
      out_ready = (cyc >= 4);
      if (cyc == 2 || cyc == 3) begin
        chk("bp_rdy", {63'd0, rdy_a}, 64'd0);
        chk("bp_hold_tag", {60'd0, tag_a}, 64'd1);
        chk("bp_hold_imm", {32'd0, imm_a}, 64'd5);
        chk("bp_acc", 64'(acc), 64'd2);
      end
      if (vld_a && out_ready) got_q.push_back(tag_a);
      if (in_valid && rdy_a) begin
        acc++;
        @(posedge clk);
        #1;
        if (in_tag == 4'd4) in_valid = 1'b0;
        else in_tag = in_tag + 4'd1;
      end else begin
        @(posedge clk);
      end
      @(negedge clk);
    end
    chk("bp_count", 64'(got_q.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < got_q.size())
        chk("bp_order", {60'd0, got_q[i]}, 64'(i + 1));
    end

    // reset while both entries are full
    @(negedge clk);
    out_ready = 1'b0;
    in_tag    = 4'd5;
    in_valid  = 1'b1;
    @(posedge clk);
    #1 in_tag = 4'd6;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("skid_pre_rdy", {63'd0, rdy_a}, 64'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_vld", {63'd0, vld_a}, 64'd0);
    chk("mrst_rdy", {63'd0, rdy_a}, 64'd1);
    chk("mrst_vld64", {63'd0, vld_b}, 64'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    in_tag   = 4'd7;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    nemit    = 0;
    last_tag = '0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (vld_a) begin
        nemit++;
        last_tag = tag_a;
      end
    end
    chk("post_rst_cnt", 64'(nemit), 64'd1);
    chk("post_rst_tag", {60'd0, last_tag}, 64'd7);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
